duty_cycle_ctrl: RTL and testbench

DUTY_CYCLE_CTRL -- requirements
Module: duty_cycle_ctrl

---
 rtl/duty_pkg.sv | 32 +++
 rtl/duty_btn_repeat.sv | 103 ++++++++++
 rtl/duty_cycle_ctrl.sv | 86 ++++++++
 tb/tb_duty_cycle_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/duty_pkg.sv
`default_nettype none
// ============================================================================
// Module   : duty_pkg
// Purpose  : Shared FSM state type, default parameter values and a counter
//            width helper for the duty-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package duty_pkg;

  // Hold/auto-repeat FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int DEF_WIDTH        = 4;
  localparam int DEF_CHANNELS     = 2;
  localparam int DEF_RESET_DUTY   = 1;
  localparam int DEF_REPEAT_DELAY = 8;
  localparam int DEF_REPEAT_RATE  = 2;
  localparam int DEF_WRAP         = 0;

  // Bits needed to hold the larger of the two tick reload values
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/duty_btn_repeat.sv
`default_nettype none
// ============================================================================
// Module   : duty_btn_repeat
// Purpose  : Button edge detection plus hold/auto-repeat FSM. Emits one-cycle
//            inc/dec requests that the parent applies at the next clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module duty_btn_repeat
  import duty_pkg::*;
#(
  parameter int SEL_W        = 1,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             up,
  input  logic             dn,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_ok,
  output logic             inc,
  output logic             dec
);

  localparam int             CNT_W      = cnt_width(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner_up;
  logic             up_q;
  logic             dn_q;
  logic [SEL_W-1:0] sel_q;

  logic up_acc;
  logic dn_acc;
  logic owner_held;
  logic hold_ok;
  logic rpt_fire;

  // Accept presses only from IDLE; dn wins a tie and a held button blocks the other
  always_comb begin
    dn_acc     = (state == IDLE) && sel_ok && dn && !dn_q && !(up && up_q);
    up_acc     = (state == IDLE) && sel_ok && up && !up_q && !dn;
    owner_held = owner_up ? up : dn;
    hold_ok    = (state != IDLE) && owner_held && (sel == sel_q);
    rpt_fire   = hold_ok && tick && (cnt == CNT_ONE);
    inc        = up_acc || (rpt_fire && owner_up);
    dec        = dn_acc || (rpt_fire && !owner_up);
  end

  // FSM, tick counter and previous-input registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      owner_up <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      sel_q    <= '0;
    end else begin
      up_q  <= up;
      dn_q  <= dn;
      sel_q <= sel;
      case (state)
        IDLE: begin
          if (dn_acc) begin
            state    <= DELAY;
            cnt      <= DELAY_LOAD;
            owner_up <= 1'b0;
          end else if (up_acc) begin
            state    <= DELAY;
            cnt      <= DELAY_LOAD;
            owner_up <= 1'b1;
          end
        end
        DELAY, REPEAT: begin
          if (!hold_ok) begin
            // release or channel change abandons the hold
            state <= IDLE;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == CNT_ONE) begin
              state <= REPEAT;
              cnt   <= RATE_LOAD;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/duty_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : duty_cycle_ctrl
// Purpose  : Multi-channel duty register bank adjusted by up/dn buttons with
//            hold-to-repeat, saturating or wrapping arithmetic, step pulse.
// Revision : 1.0 - initial release
// ============================================================================
module duty_cycle_ctrl
  import duty_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int RESET_DUTY   = DEF_RESET_DUTY,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int WRAP         = DEF_WRAP,
  localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      up,
  input  logic                      dn,
  input  logic [SEL_W-1:0]          sel,
  output logic [CHANNELS*WIDTH-1:0] duty,
  output logic                      step
);

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_DUTY);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [SEL_W:0]   CH_LIM    = (SEL_W + 1)'(CHANNELS);

  logic             sel_ok;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] chan [CHANNELS];

  // Next value for one step, holding at the rails unless wrapping is enabled
  function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v, input logic down);
    if (down) begin
      if ((v == '0) && (WRAP == 0)) return v;
      return v - ONE;
    end
    if ((v == '1) && (WRAP == 0)) return v;
    return v + ONE;
  endfunction

  // Out-of-range channel indices disable the buttons entirely
  assign sel_ok = ({1'b0, sel} < CH_LIM);

  duty_btn_repeat #(
    .SEL_W        (SEL_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .up     (up),
    .dn     (dn),
    .sel    (sel),
    .sel_ok (sel_ok),
    .inc    (inc),
    .dec    (dec)
  );

  // Step pulse marks every attempted change, including saturated ones
  always_ff @(posedge clk) begin
    if (!rst_n) step <= 1'b0;
    else        step <= inc | dec;
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    // Only the selected channel moves; the rest hold
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        chan[k] <= RESET_VAL;
      end else if ((inc || dec) && (sel == SEL_W'(k))) begin
        chan[k] <= bump(chan[k], dec);
      end
    end
    assign duty[k*WIDTH +: WIDTH] = chan[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_duty_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_duty_cycle_ctrl
// Purpose  : Directed vector bench for duty_cycle_ctrl (saturating, wrapping
//            and three-channel instances sharing the button inputs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_duty_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       up = 1'b0;
  logic       dn = 1'b0;
  logic       sel = 1'b0;
  logic [1:0] sel3 = 2'd3;

  logic [7:0]  duty_s;
  logic [7:0]  duty_w;
  logic [11:0] duty_3;
  logic        step_s;
  logic        step_w;
  logic        step_3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  duty_cycle_ctrl #(.WIDTH(4), .CHANNELS(2), .RESET_DUTY(1), .REPEAT_DELAY(3),
                    .REPEAT_RATE(2), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .tick(tick), .up(up), .dn(dn), .sel(sel),
    .duty(duty_s), .step(step_s));

  duty_cycle_ctrl #(.WIDTH(4), .CHANNELS(2), .RESET_DUTY(1), .REPEAT_DELAY(3),
                    .REPEAT_RATE(2), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .tick(tick), .up(up), .dn(dn), .sel(sel),
    .duty(duty_w), .step(step_w));

  duty_cycle_ctrl #(.WIDTH(4), .CHANNELS(3), .RESET_DUTY(1), .REPEAT_DELAY(3),
                    .REPEAT_RATE(2), .WRAP(0)) u_ch3 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .up(up), .dn(dn), .sel(sel3),
    .duty(duty_3), .step(step_3));

  typedef struct {
    logic       rst_n;
    logic       tick;
    logic       up;
    logic       dn;
    logic       sel;
    logic [3:0] e0;   // saturating ch0
    logic [3:0] e1;   // ch1 (both instances)
    logic       es;   // step (both instances)
    logic [3:0] ew0;  // wrapping ch0
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic r, input logic t, input logic u, input logic d,
                              input logic s, input int e0, input int e1, input int es,
                              input int ew0);
    vec_t v;
    v.rst_n = r; v.tick = t; v.up = u; v.dn = d; v.sel = s;
    v.e0 = 4'(e0); v.e1 = 4'(e1); v.es = 1'(es); v.ew0 = 4'(ew0);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    int ew;
    int nsteps;
    //           rst t up dn sel  e0 e1 st ew0
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 1));   // reset
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0,  2, 1, 1, 2));   // up press ch0
    tbl.push_back(mk(1, 0, 0, 0, 0,  2, 1, 0, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0,  1, 1, 1, 1));   // back to 1
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0, 1, 1, 0));   // dn x3 from 1
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0, 1, 1, 15));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 15));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0, 1, 1, 14));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 14));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0, 1, 0, 14));  // tick ignored in IDLE
    tbl.push_back(mk(1, 0, 1, 0, 1,  0, 2, 1, 14));  // up held on ch1
    tbl.push_back(mk(1, 1, 1, 0, 1,  0, 2, 0, 14));  // tick 1
    tbl.push_back(mk(1, 0, 1, 0, 1,  0, 2, 0, 14));
    tbl.push_back(mk(1, 1, 1, 0, 1,  0, 2, 0, 14));  // tick 2
    tbl.push_back(mk(1, 0, 1, 0, 1,  0, 2, 0, 14));
    tbl.push_back(mk(1, 1, 1, 0, 1,  0, 3, 1, 14));  // tick 3
    tbl.push_back(mk(1, 0, 1, 0, 1,  0, 3, 0, 14));
    tbl.push_back(mk(1, 1, 1, 0, 1,  0, 3, 0, 14));  // tick 4
    tbl.push_back(mk(1, 1, 1, 0, 1,  0, 4, 1, 14));  // tick 5
    tbl.push_back(mk(1, 1, 1, 0, 1,  0, 4, 0, 14));  // tick 6
    tbl.push_back(mk(1, 1, 1, 0, 1,  0, 5, 1, 14));  // tick 7
    tbl.push_back(mk(1, 1, 1, 0, 1,  0, 5, 0, 14));  // tick 8
    tbl.push_back(mk(1, 1, 1, 0, 1,  0, 6, 1, 14));  // tick 9
    tbl.push_back(mk(1, 1, 0, 0, 1,  0, 6, 0, 14));  // release
    tbl.push_back(mk(1, 1, 0, 0, 1,  0, 6, 0, 14));
    tbl.push_back(mk(1, 0, 0, 1, 1,  0, 5, 1, 14));  // ch1 down to 5
    tbl.push_back(mk(1, 0, 0, 0, 1,  0, 5, 0, 14));
    tbl.push_back(mk(1, 0, 1, 1, 1,  0, 4, 1, 14));  // both rise: dn wins
    tbl.push_back(mk(1, 0, 0, 1, 1,  0, 4, 0, 14));
    tbl.push_back(mk(1, 0, 1, 1, 1,  0, 4, 0, 14));  // up rises, dn held
    tbl.push_back(mk(1, 0, 0, 0, 1,  0, 4, 0, 14));
    tbl.push_back(mk(1, 0, 1, 0, 0,  1, 4, 1, 15));  // up press ch0
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 4, 0, 15));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 4, 0, 15));  // sel change in DELAY
    tbl.push_back(mk(1, 1, 1, 0, 1,  1, 4, 0, 15));
    tbl.push_back(mk(1, 1, 1, 0, 1,  1, 4, 0, 15));
    tbl.push_back(mk(1, 1, 1, 0, 1,  1, 4, 0, 15));
    tbl.push_back(mk(1, 0, 1, 1, 1,  1, 4, 0, 15));  // dn rises, up held
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 4, 0, 15));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 5, 1, 15));  // up press ch1
    tbl.push_back(mk(1, 1, 1, 0, 1,  1, 5, 0, 15));
    tbl.push_back(mk(1, 1, 1, 0, 1,  1, 5, 0, 15));
    tbl.push_back(mk(1, 1, 1, 0, 1,  1, 6, 1, 15));  // now in REPEAT
    tbl.push_back(mk(0, 1, 1, 0, 1,  1, 1, 0, 1));   // reset mid-hold
    tbl.push_back(mk(0, 1, 1, 0, 1,  1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 2, 1, 1));   // held after reset = press
    tbl.push_back(mk(1, 1, 0, 0, 1,  1, 2, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n;
      tick  = tbl[i].tick;
      up    = tbl[i].up;
      dn    = tbl[i].dn;
      sel   = tbl[i].sel;
      clk_edge();
      check($sformatf("v%0d sat_ch0", i), int'(duty_s[3:0]), int'(tbl[i].e0));
      check($sformatf("v%0d sat_ch1", i), int'(duty_s[7:4]), int'(tbl[i].e1));
      check($sformatf("v%0d sat_step", i), int'(step_s), int'(tbl[i].es));
      check($sformatf("v%0d wrap_ch0", i), int'(duty_w[3:0]), int'(tbl[i].ew0));
      check($sformatf("v%0d wrap_ch1", i), int'(duty_w[7:4]), int'(tbl[i].e1));
      check($sformatf("v%0d wrap_step", i), int'(step_w), int'(tbl[i].es));
      check($sformatf("v%0d ch3_step_badsel", i), int'(step_3), 0);
    end
    check("ch3 duty after bad sel", int'(duty_3), 12'h111);

    // Hold up on ch0 with a tick every cycle until the top rail is crossed
    sel  = 1'b0;
    sel3 = 2'd2;
    tick = 1'b0;
    up   = 1'b1;
    dn   = 1'b0;
    clk_edge();
    e0 = 2;
    ew = 2;
    nsteps = 1;
    check("hold press sat", int'(duty_s[3:0]), e0);
    check("hold press wrap", int'(duty_w[3:0]), ew);
    check("hold press ch3", int'(duty_3[11:8]), e0);
    for (int t = 1; t <= 29; t++) begin
      tick = 1'b1;
      clk_edge();
      if (t >= 3 && (t % 2) == 1) begin
        e0 = (e0 == 15) ? 15 : e0 + 1;
        ew = (ew + 1) % 16;
        nsteps++;
        check($sformatf("hold t%0d step", t), int'(step_s), 1);
      end else begin
        check($sformatf("hold t%0d step", t), int'(step_s), 0);
      end
      check($sformatf("hold t%0d sat", t), int'(duty_s[3:0]), e0);
      check($sformatf("hold t%0d wrap", t), int'(duty_w[3:0]), ew);
      check($sformatf("hold t%0d ch3", t), int'(duty_3[11:8]), e0);
    end
    check("hold step count", nsteps, 15);
    check("sat rail", int'(duty_s[3:0]), 15);
    check("wrap rail", int'(duty_w[3:0]), 0);
    check("sat last step", int'(step_s), 1);
    up = 1'b0;
    clk_edge();
    clk_edge();
    check("after release sat", int'(duty_s[3:0]), 15);
    check("after release step", int'(step_s), 0);
    check("ch3 other chans", int'(duty_3[7:0]), 8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
